// File: rtl/audio_fifo_pkg.sv
// Shared sizing helpers for the audio sample FIFO and its storage RAM.
package audio_fifo_pkg;

  localparam int DEFAULT_DEPTH = 32'sd8192;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  localparam int DEFAULT_LEVEL_W = level_width(DEFAULT_DEPTH);

endpackage

// File: rtl/audio_sdp_ram.sv
// Single-clock simple dual-port RAM with registered, read-first output.
module audio_sdp_ram
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register; returns the old word on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO with level/status flags and sticky error flags.
// Define AUDIO_SAMPLE_FIFO_FWFT_EN for first-word-fall-through output.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 16,
  parameter int AE_THRESH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          ovf,
  output logic                          udf,
  input  logic                          clr_err
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             rd_ok_s, wr_ok_s;
  logic             rd_acc_s, wr_acc_s;
  logic             ram_re_s;
`ifdef AUDIO_SAMPLE_FIFO_FWFT_EN
  logic [LVL_W-1:0] ram_cnt_s;
`endif

  // Accept decisions, pointer/level update, flag derivation.
  always_comb begin
    rd_ok_s    = 1'b0;
    wr_ok_s    = 1'b0;
    rd_acc_s   = 1'b0;
    wr_acc_s   = 1'b0;
    ram_re_s   = 1'b0;
    rd_valid_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

`ifdef AUDIO_SAMPLE_FIFO_FWFT_EN
    // The output register holds the head; the RAM only holds what is behind it.
    ram_cnt_s  = level_q - LVL_W'(rd_valid_q);
    rd_ok_s    = rd_en && rd_valid_q;
    wr_ok_s    = wr_en && (!full_q || rd_ok_s);
    rd_acc_s   = rd_ok_s && !flush;
    wr_acc_s   = wr_ok_s && !flush;
    ram_re_s   = (ram_cnt_s != '0) && (!rd_valid_q || rd_acc_s) && !flush;
    rd_valid_d = ram_re_s || (rd_valid_q && !rd_acc_s);
`else
    rd_ok_s    = rd_en && !empty_q;
    wr_ok_s    = wr_en && (!full_q || rd_ok_s);
    rd_acc_s   = rd_ok_s && !flush;
    wr_acc_s   = wr_ok_s && !flush;
    ram_re_s   = rd_acc_s;
    rd_valid_d = rd_acc_s;
`endif

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (ram_re_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_d;
    end

    // Errors are not raised by requests that a flush swallows.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (!flush) begin
      ovf_d = ovf_q || (wr_en && !wr_ok_s);
      udf_d = udf_q || (rd_en && !rd_ok_s);
    end else begin
      ovf_d = ovf_q;
      udf_d = udf_q;
    end

    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
    af_d    = (int'(level_d) >= AF_THRESH);
    ae_d    = (int'(level_d) <= AE_THRESH);
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  audio_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (ram_re_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo at DEPTH=8, DATA_W=16.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [3:0]  level;
  logic        full, empty, almost_full, almost_empty, ovf, udf;
  logic        clr_err = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mq[$];
  logic        exp_ovf = 1'b0;
  logic        exp_udf = 1'b0;

  audio_sample_fifo #(
    .DATA_W(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_level", {28'h0, level}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_ae", {31'h0, almost_empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_af", {31'h0, almost_full}, 32'd0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    chk("rst_udf", {31'h0, udf}, 32'd0);
    chk("rst_rd_data", {16'h0, rd_data}, 32'd0);
  endtask

`ifndef AUDIO_SAMPLE_FIFO_FWFT_EN
  // One clock of stimulus against a queue model of the FIFO contents.
  task automatic do_cycle(input logic w, input logic [15:0] d, input logic r);
    bit          rd_ok, wr_ok;
    logic [15:0] exp_d;
    int          sz;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < 8) || rd_ok);
    if (w && !wr_ok) exp_ovf = 1'b1;
    if (r && !rd_ok) exp_udf = 1'b1;
    exp_d = 16'h0;
    if (rd_ok) exp_d = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    wr_en = w; wr_data = d; rd_en = r;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    sz = mq.size();
    chk("level", {28'h0, level}, sz);
    chk("rd_valid", {31'h0, rd_valid}, {31'h0, rd_ok});
    if (rd_ok) chk("rd_data", {16'h0, rd_data}, {16'h0, exp_d});
    chk("full", {31'h0, full}, (sz == 8) ? 32'd1 : 32'd0);
    chk("empty", {31'h0, empty}, (sz == 0) ? 32'd1 : 32'd0);
    chk("almost_full", {31'h0, almost_full}, (sz >= 6) ? 32'd1 : 32'd0);
    chk("almost_empty", {31'h0, almost_empty}, (sz <= 2) ? 32'd1 : 32'd0);
    chk("ovf", {31'h0, ovf}, {31'h0, exp_ovf});
    chk("udf", {31'h0, udf}, {31'h0, exp_udf});
  endtask
`endif

  initial begin
    tick();
    tick();
    chk_reset_values();
    rst_n = 1'b1;
    tick();

`ifdef AUDIO_SAMPLE_FIFO_FWFT_EN
    wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    chk("fwft_level", {28'h0, level}, 32'd1);
    chk("fwft_valid_n1", {31'h0, rd_valid}, 32'd0);
    tick();
    chk("fwft_valid_n2", {31'h0, rd_valid}, 32'd1);
    chk("fwft_data", {16'h0, rd_data}, 32'h1234);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_empty", {31'h0, empty}, 32'd1);
    chk("fwft_valid_pop", {31'h0, rd_valid}, 32'd0);
    chk("fwft_udf", {31'h0, udf}, 32'd0);
`else
    // Fill 1..8, overflow with 0xBEEF, clear, drain in order.
    for (int i = 1; i <= 8; i++) do_cycle(1'b1, 16'(i), 1'b0);
    do_cycle(1'b1, 16'hBEEF, 1'b0);
    clr_err = 1'b1; exp_ovf = 1'b0; exp_udf = 1'b0;
    do_cycle(1'b0, 16'h0, 1'b0);
    clr_err = 1'b0;
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 16'h0, 1'b1);
    do_cycle(1'b0, 16'h0, 1'b0);

    // Underflow, then clear winning over a same-cycle underflow.
    do_cycle(1'b0, 16'h0, 1'b1);
    clr_err = 1'b1; exp_udf = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0; clr_err = 1'b0;
    chk("clr_priority_udf", {31'h0, udf}, 32'd0);

    // Simultaneous read/write from empty, then from full.
    for (int k = 0; k < 20; k++) do_cycle(1'b1, 16'h0100 + 16'(k), 1'b1);
    for (int k = 0; k < 7; k++) do_cycle(1'b1, 16'h0200 + 16'(k), 1'b0);
    for (int k = 0; k < 20; k++) do_cycle(1'b1, 16'h0300 + 16'(k), 1'b1);
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 16'h0, 1'b1);

    // Flush at level 5 with concurrent traffic; udf stays set.
    chk("pre_flush_level", {28'h0, level}, 32'd5);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    mq.delete();
    chk("flush_level", {28'h0, level}, 32'd0);
    chk("flush_rd_valid", {31'h0, rd_valid}, 32'd0);
    chk("flush_empty", {31'h0, empty}, 32'd1);
    chk("flush_udf_kept", {31'h0, udf}, 32'd1);
    chk("flush_ovf_kept", {31'h0, ovf}, 32'd0);
    do_cycle(1'b1, 16'hA5A5, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1);

    // Reset in the middle of a write burst.
    do_cycle(1'b1, 16'h0C00, 1'b0);
    do_cycle(1'b1, 16'h0C01, 1'b0);
    wr_en = 1'b1; wr_data = 16'h0C02;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    tick();
    chk_reset_values();
    rst_n = 1'b1;
    wr_en = 1'b0;
    mq.delete(); exp_ovf = 1'b0; exp_udf = 1'b0;
    do_cycle(1'b0, 16'h0, 1'b0);
    do_cycle(1'b1, 16'h5A5A, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8192, meaning number of entries; must be a power of two and at least 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-16, meaning almost-full level threshold.
REQ-004 SHALL have parameter AE_THRESH, default 16, meaning almost-empty level threshold.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port flush, input, 1, synchronous pulse that empties the FIFO.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port wr_data, input, DATA_W, write sample.
REQ-010 SHALL have port rd_en, input, 1, read or pop request.
REQ-011 SHALL have port rd_data, output, DATA_W, read sample.
REQ-012 SHALL have port rd_valid, output, 1, rd_data is valid.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.
REQ-014 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, status flags.
REQ-015 SHALL have ports ovf and udf, each output, 1, sticky overflow and underflow flags.
REQ-016 SHALL have port clr_err, input, 1, synchronous clear of ovf and udf.

Function
REQ-017 SHALL accept a write only when wr_en=1 and full=0; a write while full SHALL be dropped and SHALL set ovf.
REQ-018 SHALL accept a read only when rd_en=1 and a word is available; a read while nothing is available SHALL be ignored and SHALL set udf.
REQ-019 SHALL keep level registered: +1 per accepted write, -1 per accepted read, unchanged when both are accepted in the same cycle.
REQ-020 SHALL, when full and wr_en plus rd_en occur in the same cycle, accept both, keep level at DEPTH and leave ovf unchanged.
REQ-021 SHALL, when empty and wr_en plus rd_en occur in the same cycle (standard mode), accept the write, ignore the read, set udf and increment level.
REQ-022 SHALL derive full=(level==DEPTH), empty=(level==0), almost_full=(level>=AF_THRESH) and almost_empty=(level<=AE_THRESH), all registered with level.
REQ-023 SHALL wrap read and write pointers modulo DEPTH with no gap or stall at the wrap boundary.
REQ-024 SHALL, on flush, zero both pointers, level and rd_valid on the next edge, drop any concurrent write or read, and leave ovf/udf unchanged.
REQ-025 SHALL give clr_err priority over a same-cycle set of ovf or udf.
REQ-026 SHALL preserve data order exactly, with no sample duplicated or lost except writes dropped under REQ-017.

Reset
REQ-027 SHALL, while rst_n=0, hold pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, ovf=0, udf=0 and rd_data=0.
REQ-028 SHALL leave RAM contents uninitialised by reset; reset mid-transfer discards all stored data.

Configuration
REQ-029 SHALL select first-word-fall-through mode with the macro AUDIO_SAMPLE_FIFO_FWFT_EN.
REQ-030 SHALL, without the macro, run in standard mode: an accepted rd_en in cycle N presents data with rd_valid=1 in cycle N+1 only.
REQ-031 SHALL, with the macro, prefetch the head into an output register: rd_valid=1 whenever a word is available, rd_en acts as a pop, and the first write into an empty FIFO in cycle N gives rd_valid=1 in cycle N+2.
REQ-032 SHALL, with the macro, include the prefetched word in level; "available" means rd_valid=1.

Structure
REQ-033 SHALL place the pointer-width function and the level-width localparam in the shared package audio_fifo_pkg.
REQ-034 SHALL use one sub-module, audio_sdp_ram: a single-clock simple dual-port RAM, registered read, inferable as block RAM, DATA_W x DEPTH.

Verification
REQ-035 SHALL cover fill and drain with DEPTH=8, DATA_W=16: write 0x0001..0x0008, then 8 reads. Required: full=1 after the 8th write, data returns in order, empty=1 after the 8th read, udf=0.
REQ-036 SHALL cover overflow: at full, write 0xBEEF. Required: ovf=1, level stays 8, 0xBEEF is never read; clr_err then gives ovf=0.
REQ-037 SHALL cover simultaneous read and write: at level 8 and at level 0, drive wr_en and rd_en for 20 cycles. Required: level stays 8, or goes 0 to 1 with udf=1 (standard mode); pointers wrap with data intact.
REQ-038 SHALL cover flush and reset: at level 5, pulse flush, then assert rst_n=0 mid-burst. Required: level=0 and rd_valid=0 next cycle; all REQ-027 values hold.
REQ-039 SHALL cover FWFT mode (macro defined): write 0x1234 into an empty FIFO. Required: rd_valid=1 with rd_data=0x1234 two cycles later, and empty=1 one cycle after rd_en.
